rotator_nco: RTL
================

Name: rotator_nco

Overview:
- Numerically controlled oscillator that generates the sin/cos pair consumed by the I/Q phase-rotation stage, which sits directly downstream.
- A phase accumulator advances by a frequency word plus a loop phase correction.
- A quarter-wave sine table with quadrant mapping yields S(NB_OUTPUT,NBF_OUTPUT) samples.
- Samples are pipelined so that o_sin/o_cos feed the rotator's i_dataSin/i_dataCos directly.

Parameters:
- NB_PHASE, 16: phase accumulator width; full scale 2^NB_PHASE = 2π.
- NB_LUT_ADDR, 6: quarter-wave table address width (64 entries).
- NB_OUTPUT, 8: sin/cos total width.
- NBF_OUTPUT, 6: sin/cos fractional bits; 1.0 = 64.

Ports:
- clock, input, 1: system clock.
- i_reset, input, 1: synchronous, active-high reset.
- i_enable, input, 1: advance accumulator this cycle.
- i_phase_inc, input, NB_PHASE: frequency word, taken modulo 2^NB_PHASE.
- i_phase_err, input, NB_PHASE (signed): loop correction added each enabled cycle.
- i_load, input, 1: force the accumulator to i_load_phase.
- i_load_phase, input, NB_PHASE: phase value for i_load.
- o_sin, output, NB_OUTPUT (signed): sine sample.
- o_cos, output, NB_OUTPUT (signed): cosine sample.
- o_phase, output, NB_PHASE: accumulator value aligned with o_sin/o_cos.
- o_valid, output, 1: o_sin/o_cos/o_phase hold a new sample.

Behaviour:
- Reset (synchronous): accumulator, all pipeline registers, o_sin, o_cos, o_phase and o_valid are 0. Reset dominates i_load and i_enable. Reset mid-stream flushes the pipeline: o_valid is 0 on the following cycles until new enabled samples emerge.
- Stage 0 (accumulator, edge e0):
  - If i_load: acc <= i_load_phase; v0 <= 1.
  - Else if i_enable: acc <= acc + i_phase_inc + i_phase_err, modular NB_PHASE-bit wrap with no saturation; v0 <= 1.
  - Else: acc holds; v0 <= 0.
- Stage 1 (edge e1):
  - q = acc[NB_PHASE-1:NB_PHASE-2]; a = acc[NB_PHASE-3 -: NB_LUT_ADDR]; low bits are truncated.
  - Register L[a], L[~a] (bitwise inverse address), q, acc and v1 <= v0.
- Stage 2 (edge e2): register the outputs and o_valid <= v1.
  - q=0: sin = L[a], cos = L[~a].
  - q=1: sin = L[~a], cos = -L[a].
  - q=2: sin = -L[a], cos = -L[~a].
  - q=3: sin = -L[~a], cos = L[a].
- Latency: inputs sampled at e0 appear on the outputs after e2, i.e. 3 edges. One sample per clock when enabled; no backpressure.
- Table contents: L[k] = round(sin(π/2·(k+0.5)/2^NB_LUT_ADDR)·2^NBF_OUTPUT), k = 0..2^NB_LUT_ADDR-1.
  - With defaults, L[0] = 1 and L[63] = 64.
  - The half-LSB offset removes the ±0 ambiguity. All entries and their negations fit in NB_OUTPUT bits, so no saturation is needed.
  - The table is a fixed constant function, evaluated at elaboration.
- Simultaneous i_load and i_enable: load wins and the increment is ignored that cycle.
- Enable low: the pipeline keeps shifting and o_valid drops 2 cycles later; the outputs keep their last valid values until they are overwritten.
- Accumulator wrap, e.g. 0xFFFF + 1 → 0x0000, is silent and correct by construction.

Decomposition:
- Package rotator_pkg:
  - NB_PHASE, NB_LUT_ADDR, NB_OUTPUT, NBF_OUTPUT defaults.
  - Quadrant encodings Q0..Q3.
  - LUT_DEPTH = 2^NB_LUT_ADDR.
  - Table-generation function.
- Sub-module quarter_sine_rom: a two-read-port registered ROM (addresses a and ~a), which forms stage 1.
- The top level holds the accumulator, quadrant/sign logic and valid pipeline.

Test Plan:
1. Reset held 3 cycles, then released with i_enable=0 → o_sin = o_cos = o_phase = 0 and o_valid = 0 throughout.
2. i_load with i_load_phase = 0x0000, 0x4000, 0x8000, 0xC000 on consecutive cycles → after 3 edges, consecutive (sin,cos) = (1,64), (64,-1), (-1,-64), (-64,1); o_valid = 1 and o_phase matches each loaded value.
3. Load 0xFFFF, then enable with inc = 1, err = 0 → o_phase sequence 0xFFFF, 0x0000, 0x0001; (sin,cos) goes from (-1,64) to (1,64).
4. inc = 0x0400, err = 0x0000 versus inc = 0x0300, err = 0x0100 → identical output streams; with err = 0xFC00 (−0x400) and inc = 0x0400 the phase stays constant.
5. i_load and i_enable asserted together, load = 0x4000, inc = 0x1000 → o_phase = 0x4000 (not 0x5000).
6. Reset asserted while o_valid = 1 in steady state → o_valid = 0 and outputs = 0 on the next edge; no stale samples appear after reset release without enable.

Source files
------------

// File: rtl/rotator_pkg.sv
// Shared constants, quadrant encoding and the quarter-wave table generator
// for the rotator NCO.
package rotator_pkg;

  localparam int NB_PHASE_DEF    = 16;
  localparam int NB_LUT_ADDR_DEF = 6;
  localparam int NB_OUTPUT_DEF   = 8;
  localparam int NBF_OUTPUT_DEF  = 6;
  localparam int LUT_DEPTH       = 1 << NB_LUT_ADDR_DEF;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_t;

  localparam real PI = 3.14159265358979323846;

  // Half-LSB address offset keeps every entry strictly positive, so the
  // quadrant mirroring never has to deal with a signed zero.
  function automatic logic [31:0] sine_entry(input int k, input int nb_addr, input int nbf);
    real theta;
    real scaled;
    theta  = (PI / 2.0) * (real'(k) + 0.5) / real'(1 << nb_addr);
    scaled = $sin(theta) * real'(1 << nbf);
    return 32'($rtoi(scaled + 0.5));
  endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// Two-read-port quarter-wave sine table; reads L[a] and L[~a] in one
// registered cycle (pipeline stage 1).
module quarter_sine_rom
  import rotator_pkg::*;
#(
  parameter int NB_LUT_ADDR = NB_LUT_ADDR_DEF,
  parameter int NB_OUTPUT   = NB_OUTPUT_DEF,
  parameter int NBF_OUTPUT  = NBF_OUTPUT_DEF
) (
  input  logic                   clock,
  input  logic                   i_reset,
  input  logic [NB_LUT_ADDR-1:0] addr,
  output logic [NB_OUTPUT-1:0]   lut_a,
  output logic [NB_OUTPUT-1:0]   lut_inv
);

  localparam int DEPTH = 1 << NB_LUT_ADDR;

  logic [NB_OUTPUT-1:0] table_rom [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_table
    logic [31:0] entry;
    assign entry         = sine_entry(gi, NB_LUT_ADDR, NBF_OUTPUT);
    assign table_rom[gi] = entry[NB_OUTPUT-1:0];
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      lut_a   <= '0;
      lut_inv <= '0;
    end else begin
      lut_a   <= table_rom[addr];
      lut_inv <= table_rom[~addr];
    end
  end

endmodule

// File: rtl/rotator_nco.sv
// NCO feeding the I/Q rotator: phase accumulator, quarter-wave lookup and
// quadrant mapping, three edges from input sample to o_sin/o_cos.
module rotator_nco
  import rotator_pkg::*;
#(
  parameter int NB_PHASE    = NB_PHASE_DEF,
  parameter int NB_LUT_ADDR = NB_LUT_ADDR_DEF,
  parameter int NB_OUTPUT   = NB_OUTPUT_DEF,
  parameter int NBF_OUTPUT  = NBF_OUTPUT_DEF
) (
  input  logic                        clock,
  input  logic                        i_reset,
  input  logic                        i_enable,
  input  logic [NB_PHASE-1:0]         i_phase_inc,
  input  logic signed [NB_PHASE-1:0]  i_phase_err,
  input  logic                        i_load,
  input  logic [NB_PHASE-1:0]         i_load_phase,
  output logic signed [NB_OUTPUT-1:0] o_sin,
  output logic signed [NB_OUTPUT-1:0] o_cos,
  output logic [NB_PHASE-1:0]         o_phase,
  output logic                        o_valid
);

  logic [NB_PHASE-1:0] acc_reg;
  logic                v0_reg;
  logic [NB_PHASE-1:0] phase1_reg;
  quadrant_t           quad1_reg;
  logic                v1_reg;
  logic [NB_OUTPUT-1:0] lut_a;
  logic [NB_OUTPUT-1:0] lut_inv;
  logic [NB_OUTPUT-1:0] sin_next;
  logic [NB_OUTPUT-1:0] cos_next;

  // Stage 0: modular accumulate; the signed error adds identically as two's complement.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      acc_reg <= '0;
      v0_reg  <= 1'b0;
    end else if (i_load) begin
      acc_reg <= i_load_phase;
      v0_reg  <= 1'b1;
    end else if (i_enable) begin
      acc_reg <= acc_reg + i_phase_inc + NB_PHASE'(i_phase_err);
      v0_reg  <= 1'b1;
    end else begin
      v0_reg  <= 1'b0;
    end
  end

  quarter_sine_rom #(
    .NB_LUT_ADDR(NB_LUT_ADDR),
    .NB_OUTPUT  (NB_OUTPUT),
    .NBF_OUTPUT (NBF_OUTPUT)
  ) u_rom (
    .clock  (clock),
    .i_reset(i_reset),
    .addr   (acc_reg[NB_PHASE-3 -: NB_LUT_ADDR]),
    .lut_a  (lut_a),
    .lut_inv(lut_inv)
  );

  // Stage 1 side registers, kept aligned with the ROM read.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      phase1_reg <= '0;
      quad1_reg  <= Q0;
      v1_reg     <= 1'b0;
    end else begin
      phase1_reg <= acc_reg;
      quad1_reg  <= quadrant_t'(acc_reg[NB_PHASE-1 -: 2]);
      v1_reg     <= v0_reg;
    end
  end

  always_comb begin
    sin_next = lut_a;
    cos_next = lut_inv;
    case (quad1_reg)
      Q0: begin sin_next = lut_a;    cos_next = lut_inv;  end
      Q1: begin sin_next = lut_inv;  cos_next = -lut_a;   end
      Q2: begin sin_next = -lut_a;   cos_next = -lut_inv; end
      Q3: begin sin_next = -lut_inv; cos_next = lut_a;    end
      default: begin sin_next = lut_a; cos_next = lut_inv; end
    endcase
  end

  // Stage 2: outputs only update on valid samples so they hold through gaps.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      o_sin   <= '0;
      o_cos   <= '0;
      o_phase <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= v1_reg;
      if (v1_reg) begin
        o_sin   <= sin_next;
        o_cos   <= cos_next;
        o_phase <= phase1_reg;
      end
    end
  end

endmodule
